// File: rtl/vec_operand_fetch.sv
`timescale 1ns/1ps
// Operand-fetch sequencer: walks vs1/vs2 packet by packet over two register-file
// read ports, absorbs the 1-cycle read latency and queues aligned operand pairs
// in a 2-entry FIFO towards the ALU.
module vec_operand_fetch #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DW_B       = DATA_WIDTH / 8,
   parameter int unsigned OFF_BITS   = 8,
   parameter int unsigned VL_BITS    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_vs1,
   input  logic [ADDR_WIDTH-1:0] cmd_vs2,
   input  logic [VL_BITS-1:0]    cmd_vl,
   output logic [DW_B-1:0]       rd_en_1,
   output logic [ADDR_WIDTH-1:0] rd_addr_1,
   output logic [OFF_BITS-1:0]   rd_off_1,
   output logic [DW_B-1:0]       rd_en_2,
   output logic [ADDR_WIDTH-1:0] rd_addr_2,
   output logic [OFF_BITS-1:0]   rd_off_2,
   input  logic [DATA_WIDTH-1:0] rd_data_in_1,
   input  logic [DATA_WIDTH-1:0] rd_data_in_2,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b,
   output logic [DW_B-1:0]       op_be,
   output logic                  op_last,
   output logic                  busy
);

   localparam int unsigned TAIL_W = $clog2(DW_B);
   localparam int unsigned NPKT_W = VL_BITS - TAIL_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   vs1_q, vs1_d, vs2_q, vs2_d;
   logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d, addr2_q, addr2_d;
   logic [OFF_BITS-1:0]     off_q, off_d, last_off_q, last_off_d;
   logic [NPKT_W-1:0]       npkt_q, npkt_d;
   logic [TAIL_W-1:0]       tail_q, tail_d;
   logic                    pend_q, pend_d;
   logic [DW_B-1:0]         pend_be_q, pend_be_d;
   logic                    pend_last_q, pend_last_d;

   logic [DATA_WIDTH-1:0]   fa_q [2];
   logic [DATA_WIDTH-1:0]   fb_q [2];
   logic [DW_B-1:0]         fbe_q [2];
   logic [1:0]              flast_q;
   logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]              cnt_q, cnt_d;

   logic                    push, pop, issue, is_last;
   logic [1:0]              occ;
   logic [DW_B-1:0]         mask;

   // Issue control: occupancy counts the packet still in flight in the file
   assign push    = pend_q;
   assign pop     = op_valid && op_ready;
   assign occ     = cnt_q + {1'b0, pend_q};
   assign is_last = (NPKT_W'(off_q) == (npkt_q - NPKT_W'(1)));
   assign issue   = (state_q == ISSUE) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
   assign mask    = (is_last && (tail_q != '0)) ? ~({DW_B{1'b1}} << tail_q) : {DW_B{1'b1}};

   // Read-port drive: enables only on issue, address/offset hold last issued values
   assign rd_en_1   = issue ? mask : '0;
   assign rd_en_2   = issue ? mask : '0;
   assign rd_addr_1 = issue ? vs1_q : addr1_q;
   assign rd_addr_2 = issue ? vs2_q : addr2_q;
   assign rd_off_1  = issue ? off_q : last_off_q;
   assign rd_off_2  = issue ? off_q : last_off_q;

   // FIFO head presented to the ALU
   assign op_valid  = (cnt_q != 2'd0);
   assign op_a      = op_valid ? fa_q[rd_ptr_q]  : '0;
   assign op_b      = op_valid ? fb_q[rd_ptr_q]  : '0;
   assign op_be     = op_valid ? fbe_q[rd_ptr_q] : '0;
   assign op_last   = op_valid && flast_q[rd_ptr_q];
   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   // FIFO pointer/count next state
   assign cnt_d    = cnt_q + 2'(push) - 2'(pop);
   assign wr_ptr_d = wr_ptr_q ^ push;
   assign rd_ptr_d = rd_ptr_q ^ pop;

   // Command sequencing next state
   always_comb begin
      state_d     = state_q;
      vs1_d       = vs1_q;
      vs2_d       = vs2_q;
      npkt_d      = npkt_q;
      tail_d      = tail_q;
      off_d       = off_q;
      addr1_d     = addr1_q;
      addr2_d     = addr2_q;
      last_off_d  = last_off_q;
      pend_d      = issue;
      pend_be_d   = pend_be_q;
      pend_last_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               vs1_d  = cmd_vs1;
               vs2_d  = cmd_vs2;
               tail_d = cmd_vl[TAIL_W-1:0];
               npkt_d = NPKT_W'(cmd_vl >> TAIL_W) + NPKT_W'(cmd_vl[TAIL_W-1:0] != '0);
               off_d  = '0;
               if (cmd_vl != '0) state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (issue) begin
               addr1_d     = vs1_q;
               addr2_d     = vs2_q;
               last_off_d  = off_q;
               pend_be_d   = mask;
               pend_last_d = is_last;
               if (is_last) state_d = DRAIN;
               else         off_d   = off_q + OFF_BITS'(1);
            end
         end
         DRAIN: begin
            if ((cnt_q == 2'd0) && !pend_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, command and FIFO registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         vs1_q       <= '0;
         vs2_q       <= '0;
         npkt_q      <= '0;
         tail_q      <= '0;
         off_q       <= '0;
         addr1_q     <= '0;
         addr2_q     <= '0;
         last_off_q  <= '0;
         pend_q      <= 1'b0;
         pend_be_q   <= '0;
         pend_last_q <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         flast_q     <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            fa_q[i]  <= '0;
            fb_q[i]  <= '0;
            fbe_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         vs1_q       <= vs1_d;
         vs2_q       <= vs2_d;
         npkt_q      <= npkt_d;
         tail_q      <= tail_d;
         off_q       <= off_d;
         addr1_q     <= addr1_d;
         addr2_q     <= addr2_d;
         last_off_q  <= last_off_d;
         pend_q      <= pend_d;
         pend_be_q   <= pend_be_d;
         pend_last_q <= pend_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         if (push) begin
            fa_q[wr_ptr_q]    <= rd_data_in_1;
            fb_q[wr_ptr_q]    <= rd_data_in_2;
            fbe_q[wr_ptr_q]   <= pend_be_q;
            flast_q[wr_ptr_q] <= pend_last_q;
         end
      end
   end

endmodule

// File: doc/vec_operand_fetch.md
Name: vec_operand_fetch

Overview:
- Operand-fetch sequencer sitting directly upstream of the vector register file's two read ports.
- Accepts one vector command at a time: source registers vs1 and vs2, plus vector length in bytes.
- Walks both sources packet by packet (DATA_WIDTH bits per packet) using register-file read ports 1 and 2.
- Absorbs the file's 1-cycle read latency and delivers aligned operand pairs to the ALU over a valid/ready interface with backpressure.

Parameters:
- ADDR_WIDTH, 5, vector register index width.
- DATA_WIDTH, 64, packet width in bits.
- DW_B, DATA_WIDTH/8, packet width in bytes.
- OFF_BITS, 8, packet offset width within a register.
- VL_BITS, 12, width of cmd_vl (bytes, 1..DW_B<<OFF_BITS).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_vs1  in  ADDR_WIDTH  source register A.
- cmd_vs2  in  ADDR_WIDTH  source register B.
- cmd_vl  in  VL_BITS  vector length in bytes.
- rd_en_1  out  DW_B  read port 1 byte enables.
- rd_addr_1  out  ADDR_WIDTH  read port 1 register index.
- rd_off_1  out  OFF_BITS  read port 1 packet offset.
- rd_en_2  out  DW_B  read port 2 byte enables.
- rd_addr_2  out  ADDR_WIDTH  read port 2 register index.
- rd_off_2  out  OFF_BITS  read port 2 packet offset.
- rd_data_in_1  in  DATA_WIDTH  register-file read data, port 1.
- rd_data_in_2  in  DATA_WIDTH  register-file read data, port 2.
- op_valid  out  1  operand pair available.
- op_ready  in  1  ALU accepts the pair.
- op_a  out  DATA_WIDTH  packet from vs1.
- op_b  out  DATA_WIDTH  packet from vs2.
- op_be  out  DW_B  valid-byte mask for the packet.
- op_last  out  1  final packet of the command.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, FIFO empty, pending=0. All rd_* = 0, op_valid=0, op_a/op_b/op_be/op_last = 0, busy=0, cmd_ready=1. Reset mid-command abandons it; in-flight data is discarded.
- cmd_ready = (state==IDLE). Handshake completes on cmd_valid&&cmd_ready.
- Accepting a command latches vs1, vs2, npkt = ceil(vl/DW_B) and tail = vl mod DW_B, and clears off to 0.
- vl==0 is accepted and dropped: no reads, no outputs, state stays IDLE.
- States:
  - IDLE -> ISSUE on accept with vl!=0.
  - ISSUE -> DRAIN on the cycle the last packet issues.
  - DRAIN -> IDLE when FIFO empty, pending==0 and no pop pending.
- Issue (ISSUE only): a 2-entry output FIFO holds operand pairs. pending = 1 for the cycle after an issue.
  - Issue allowed when FIFO count + pending < 2, or when it equals 2 and a pop occurs this cycle.
  - On issue: rd_addr_1=vs1, rd_addr_2=vs2, rd_off_1=rd_off_2=off, rd_en_1=rd_en_2=mask, then off++.
  - mask is all ones, except on the last packet when tail!=0: mask = (1<<tail)-1.
  - When not issuing, rd_en_*=0. rd_addr/rd_off hold their last values.
- Latency: the file registers data at the issue-cycle edge. In the next cycle rd_data_in_1/2 are captured into the FIFO with mask and last flag. op_valid rises the following cycle.
  - Accept at cycle T -> first issue T+1 -> capture at end of T+2 -> op_valid at T+3.
- Throughput: with op_ready held high, one packet per cycle sustained.
- FIFO head drives op_a/op_b/op_be/op_last combinationally. Pop on op_valid&&op_ready. Simultaneous push and pop on a full FIFO is legal. Count never exceeds 2, so no overflow is possible.
- op_last=1 only with the final packet. Outputs hold stable while op_valid&&!op_ready.
- Offset wrap: max npkt = 2^OFF_BITS; off never exceeds npkt-1.
- A new command is not accepted until DRAIN completes. No overlap between commands.

Test Plan:
- Reset asserted mid-ISSUE -> outputs zero immediately (async); cmd_ready=1 after release; no stray op_valid.
- vs1=3, vs2=7, vl=20, op_ready=1 -> offsets 0,1,2 with rd_en 0xFF,0xFF,0x0F. Three pairs out; op_be 0xFF,0xFF,0x0F; op_last only on the third. op_valid first at accept+3.
- vl=0 -> accepted in one cycle; no rd_en activity; op_valid stays 0; busy stays 0.
- vl=64, op_ready=0 for 10 cycles then 1 -> exactly 2 issues, then stall with rd_en=0. All 8 packets then delivered in order with none lost or duplicated, data matching reg[3]/reg[7] offsets 0..7.
- vl=2048 (max) -> 256 packets with offsets 0..255 and no wrap; op_last on packet 255; back-to-back command accepted only after DRAIN.
- Random op_ready toggling, vl=100 -> op_a/op_b sequences match the model; the head pair holds stable while op_ready=0.
